// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch sequencer: owns the NZCV flag register, resolves decoded
// branches against a flag snapshot, redirects fetch and holds a flush window.
module branch_resolve_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_flags_we,
  input  logic [3:0]        alu_flags,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [3:0]        flags,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nottaken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESOLVE,
    S_REDIRECT,
    S_FLUSH
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_reg, state_next;
  logic [3:0]          flags_reg;
  logic [3:0]          cond_reg;
  logic [3:0]          snap_reg;
  logic [ADDR_W-1:0]   target_reg;
  logic                redirect_valid_reg, redirect_valid_next;
  logic [ADDR_W-1:0]   redirect_pc_reg, redirect_pc_next;
  logic                flush_reg, flush_next;
  logic [FC_W-1:0]     flush_cnt_reg, flush_cnt_next;
  logic [CNT_W-1:0]    taken_cnt_reg, nottaken_cnt_reg;
  logic                taken_inc, nottaken_inc;
  logic                accept;
  logic                cond_base;
  logic                cond_taken;

  assign br_ready       = (state_reg == S_IDLE);
  assign accept         = br_valid & br_ready;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign flush          = flush_reg;
  assign flags          = flags_reg;
  assign taken_cnt      = taken_cnt_reg;
  assign nottaken_cnt   = nottaken_cnt_reg;

  // Odd codes are the complement of the preceding even code; NV = !AL.
  always_comb begin
    cond_base = 1'b1;
    case (cond_reg[3:1])
      3'd0: cond_base = snap_reg[2];
      3'd1: cond_base = snap_reg[1];
      3'd2: cond_base = snap_reg[3];
      3'd3: cond_base = snap_reg[0];
      3'd4: cond_base = snap_reg[1] & ~snap_reg[2];
      3'd5: cond_base = (snap_reg[3] == snap_reg[0]);
      3'd6: cond_base = ~snap_reg[2] & (snap_reg[3] == snap_reg[0]);
      default: cond_base = 1'b1;
    endcase
    cond_taken = cond_base ^ cond_reg[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= 4'd0;
    end else if (alu_flags_we) begin
      flags_reg <= alu_flags;
    end
  end

  // The snapshot forwards a same-cycle flag write so the branch sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_reg   <= 4'd0;
      snap_reg   <= 4'd0;
      target_reg <= '0;
    end else if (accept) begin
      cond_reg   <= br_cond;
      snap_reg   <= alu_flags_we ? alu_flags : flags_reg;
      target_reg <= br_target;
    end
  end

  always_comb begin
    state_next          = state_reg;
    redirect_valid_next = redirect_valid_reg;
    redirect_pc_next    = redirect_pc_reg;
    flush_next          = flush_reg;
    flush_cnt_next      = flush_cnt_reg;
    taken_inc           = 1'b0;
    nottaken_inc        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (cond_taken) begin
          taken_inc           = 1'b1;
          redirect_valid_next = 1'b1;
          redirect_pc_next    = target_reg;
          state_next          = S_REDIRECT;
        end else begin
          nottaken_inc = 1'b1;
          state_next   = S_IDLE;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          redirect_valid_next = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            flush_next     = 1'b1;
            flush_cnt_next = FC_W'(FLUSH_CYCLES);
            state_next     = S_FLUSH;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_reg <= FC_W'(1)) begin
          flush_next     = 1'b0;
          flush_cnt_next = '0;
          state_next     = S_IDLE;
        end else begin
          flush_cnt_next = flush_cnt_reg - FC_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_IDLE;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      flush_reg          <= 1'b0;
      flush_cnt_reg      <= '0;
    end else begin
      state_reg          <= state_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
      flush_reg          <= flush_next;
      flush_cnt_reg      <= flush_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_reg    <= '0;
      nottaken_cnt_reg <= '0;
    end else if (cnt_clr) begin
      taken_cnt_reg    <= '0;
      nottaken_cnt_reg <= '0;
    end else begin
      if (taken_inc && (taken_cnt_reg != CNT_MAX)) begin
        taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
      end
      if (nottaken_inc && (nottaken_cnt_reg != CNT_MAX)) begin
        nottaken_cnt_reg <= nottaken_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: main instance with default widths and
// a small-counter, no-flush instance for saturation and FLUSH_CYCLES=0.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_flags_we = 1'b0;
  logic [3:0]  alu_flags = 4'd0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [3:0]  br_cond = 4'd0;
  logic [31:0] br_target = 32'd0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [3:0]  flags;
  logic        cnt_clr = 1'b0;
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;

  logic        br_valid2 = 1'b0;
  logic        br_ready2;
  logic [3:0]  br_cond2 = 4'd0;
  logic [31:0] br_target2 = 32'd0;
  logic        redirect_valid2;
  logic        redirect_ready2 = 1'b0;
  logic [31:0] redirect_pc2;
  logic        flush2;
  logic [3:0]  flags2;
  logic        cnt_clr2 = 1'b0;
  logic [2:0]  taken_cnt2;
  logic [2:0]  nottaken_cnt2;

  int checks = 0;
  int errors = 0;
  int sweep_taken = 0;
  int sweep_nt = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .alu_flags_we(alu_flags_we), .alu_flags(alu_flags),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .flags(flags), .cnt_clr(cnt_clr),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  branch_resolve_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(0), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .alu_flags_we(alu_flags_we), .alu_flags(alu_flags),
    .br_valid(br_valid2), .br_ready(br_ready2), .br_cond(br_cond2), .br_target(br_target2),
    .redirect_valid(redirect_valid2), .redirect_ready(redirect_ready2),
    .redirect_pc(redirect_pc2), .flush(flush2), .flags(flags2), .cnt_clr(cnt_clr2),
    .taken_cnt(taken_cnt2), .nottaken_cnt(nottaken_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_br_ready got %b exp 1", br_ready); end
    checks++; if (flags !== 4'd0) begin errors++; $display("FAIL reset_flags got %h exp 0", flags); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", redirect_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (taken_cnt !== 16'd0 || nottaken_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", taken_cnt, nottaken_cnt);
    end
    $display("reset: checked idle state");
  endtask

  task automatic test_taken_eq();
    alu_flags_we = 1'b1; alu_flags = 4'b0100; redirect_ready = 1'b1;
    tick();
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL flag_load got %b exp 0100", flags); end
    alu_flags_we = 1'b0; br_valid = 1'b1; br_cond = 4'h0; br_target = 32'h100;
    tick();
    br_valid = 1'b0;
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL resolve_busy got %b exp 0", br_ready); end
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
      errors++; $display("FAIL eq_redirect got v=%b pc=%h exp v=1 pc=100", redirect_valid, redirect_pc);
    end
    checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL eq_taken_cnt got %0d exp 1", taken_cnt); end
    tick();
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b1) begin
      errors++; $display("FAIL eq_flush1 got v=%b f=%b exp v=0 f=1", redirect_valid, flush);
    end
    tick();
    checks++; if (flush !== 1'b1 || br_ready !== 1'b0) begin
      errors++; $display("FAIL eq_flush2 got f=%b rdy=%b exp f=1 rdy=0", flush, br_ready);
    end
    tick();
    checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin
      errors++; $display("FAIL eq_flush_end got f=%b rdy=%b exp f=0 rdy=1", flush, br_ready);
    end
    $display("branch EQ target=100 flags=0100: taken");
  endtask

  task automatic test_not_taken();
    alu_flags_we = 1'b1; alu_flags = 4'b0000;
    tick();
    alu_flags_we = 1'b0; br_valid = 1'b1; br_cond = 4'h0; br_target = 32'h200;
    tick();
    br_valid = 1'b0;
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL nt_busy got %b exp 0", br_ready); end
    tick();
    checks++; if (br_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL nt_done got rdy=%b v=%b f=%b exp 1 0 0", br_ready, redirect_valid, flush);
    end
    checks++; if (nottaken_cnt !== 16'd1) begin errors++; $display("FAIL nt_cnt got %0d exp 1", nottaken_cnt); end
    $display("branch EQ flags=0000: not taken");
  endtask

  task automatic test_forward();
    alu_flags_we = 1'b1; alu_flags = 4'b0100;
    br_valid = 1'b1; br_cond = 4'h1; br_target = 32'h300;
    tick();
    alu_flags_we = 1'b0; br_valid = 1'b0;
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL fwd_flags got %b exp 0100", flags); end
    tick();
    checks++; if (redirect_valid !== 1'b0 || nottaken_cnt !== 16'd2 || br_ready !== 1'b1) begin
      errors++; $display("FAIL fwd_ne got v=%b nt=%0d rdy=%b exp v=0 nt=2 rdy=1", redirect_valid, nottaken_cnt, br_ready);
    end
    $display("branch NE forwarded Z=1: not taken");
  endtask

  task automatic test_stall();
    redirect_ready = 1'b0;
    br_valid = 1'b1; br_cond = 4'h0; br_target = 32'hDEADBEE0;
    tick();
    br_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'hDEADBEE0 || br_ready !== 1'b0 || flush !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b pc=%h rdy=%b f=%b exp 1 deadbee0 0 0",
                 i, redirect_valid, redirect_pc, br_ready, flush);
      end
      if (i < 4) tick();
    end
    redirect_ready = 1'b1;
    tick();
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b1 || taken_cnt !== 16'd2) begin
      errors++; $display("FAIL stall_hs got v=%b f=%b tk=%0d exp 0 1 2", redirect_valid, flush, taken_cnt);
    end
    tick();
    tick();
    checks++; if (br_ready !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL stall_end got rdy=%b f=%b exp 1 0", br_ready, flush);
    end
    $display("branch EQ target=deadbee0 with 5-cycle stall: taken");
  endtask

  task automatic test_sweep();
    logic exp;
    redirect_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        alu_flags_we = 1'b1; alu_flags = 4'(f);
        tick();
        alu_flags_we = 1'b0; br_valid = 1'b1; br_cond = 4'(c); br_target = 32'(c * 16 + f);
        tick();
        br_valid = 1'b0;
        tick();
        exp = exp_taken(4'(c), 4'(f));
        if (exp) sweep_taken++; else sweep_nt++;
        checks++;
        if (redirect_valid !== exp) begin
          errors++; $display("FAIL sweep cond=%h flags=%b got %b exp %b", c, f, redirect_valid, exp);
        end
        $display("sweep cond=%h flags=%b taken=%b", c, f, redirect_valid);
        begin
          int k;
          k = 0;
          while (br_ready !== 1'b1 && k < 10) begin
            tick();
            k++;
          end
          if (br_ready !== 1'b1) begin
            errors++; $display("FAIL sweep_timeout cond=%h flags=%b br_ready=%b exp 1", c, f, br_ready);
          end
        end
      end
    end
    checks++; if (taken_cnt !== 16'(2 + sweep_taken) || nottaken_cnt !== 16'(2 + sweep_nt)) begin
      errors++; $display("FAIL sweep_cnt got %0d/%0d exp %0d/%0d", taken_cnt, nottaken_cnt, 2 + sweep_taken, 2 + sweep_nt);
    end
  endtask

  task automatic test_clr();
    alu_flags_we = 1'b1; alu_flags = 4'b0100;
    tick();
    alu_flags_we = 1'b0; br_valid = 1'b1; br_cond = 4'h0; br_target = 32'h400;
    tick();
    br_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (taken_cnt !== 16'd0 || nottaken_cnt !== 16'd0 || redirect_valid !== 1'b1) begin
      errors++; $display("FAIL clr_wins got tk=%0d nt=%0d v=%b exp 0 0 1", taken_cnt, nottaken_cnt, redirect_valid);
    end
    tick(); tick(); tick();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL clr_end got rdy=%b exp 1", br_ready); end
    $display("branch EQ with cnt_clr in resolve: counters cleared");
  endtask

  task automatic test_saturate_noflush();
    for (int i = 1; i <= 9; i++) begin
      br_valid2 = 1'b1; br_cond2 = 4'hE; br_target2 = 32'(i * 16);
      tick();
      br_valid2 = 1'b0;
      tick();
      checks++;
      if (redirect_valid2 !== 1'b1 || redirect_pc2 !== 32'(i * 16) || taken_cnt2 !== 3'((i > 7) ? 7 : i)) begin
        errors++; $display("FAIL sat_resolve %0d got v=%b pc=%h tk=%0d exp 1 %h %0d",
                           i, redirect_valid2, redirect_pc2, taken_cnt2, i * 16, (i > 7) ? 7 : i);
      end
      redirect_ready2 = 1'b1;
      tick();
      redirect_ready2 = 1'b0;
      checks++;
      if (redirect_valid2 !== 1'b0 || flush2 !== 1'b0 || br_ready2 !== 1'b1) begin
        errors++; $display("FAIL noflush_done %0d got v=%b f=%b rdy=%b exp 0 0 1", i, redirect_valid2, flush2, br_ready2);
      end
      $display("small dut branch AL #%0d taken_cnt=%0d", i, taken_cnt2);
    end
  endtask

  task automatic test_reset_in_flush();
    alu_flags_we = 1'b1; alu_flags = 4'b0100; redirect_ready = 1'b1;
    tick();
    alu_flags_we = 1'b0; br_valid = 1'b1; br_cond = 4'h0; br_target = 32'h500;
    tick();
    br_valid = 1'b0;
    tick();
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rst_pre_flush got %b exp 1", flush); end
    rst_n = 1'b0;
    #1;
    checks++; if (flush !== 1'b0 || br_ready !== 1'b1 || redirect_valid !== 1'b0 || taken_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_mid_flush got f=%b rdy=%b v=%b tk=%0d exp 0 1 0 0", flush, br_ready, redirect_valid, taken_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || br_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_retry got f=%b v=%b rdy=%b exp 0 0 1", flush, redirect_valid, br_ready);
    end
    $display("reset during flush: aborted");
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_reset();
    test_taken_eq();
    test_not_taken();
    test_forward();
    test_stall();
    test_sweep();
    test_clr();
    test_saturate_noflush();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequencing controller for conditional branches in the RISC pipeline.
- Keeps the architectural NZCV flag register, updated from the ALU.
- Accepts branch requests from decode and resolves each against a flag snapshot, using the team's standard 4-bit condition encoding.
- On a taken branch, drives a PC redirect to fetch through a valid/ready handshake, then holds a flush for a programmable number of cycles; also keeps saturating taken/not-taken statistics counters.

Parameters:
- ADDR_W, 32, width of branch target / redirect PC
- FLUSH_CYCLES, 2, cycles flush stays high after redirect handshake (0 = no flush phase)
- CNT_W, 16, width of statistics counters

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_flags_we  input  1  ALU result carries flag update this cycle
- alu_flags  input  4  {N,Z,C,V} from ALU
- br_valid  input  1  branch request from decode
- br_ready  output  1  controller can accept a branch
- br_cond  input  4  condition code
- br_target  input  ADDR_W  branch target address
- redirect_valid  output  1  redirect request to fetch
- redirect_ready  input  1  fetch accepts redirect
- redirect_pc  output  ADDR_W  redirect address
- flush  output  1  squash younger pipeline stages
- flags  output  4  current architectural {N,Z,C,V}
- cnt_clr  input  1  synchronous clear of statistics counters
- taken_cnt  output  CNT_W  taken branches, saturating
- nottaken_cnt  output  CNT_W  not-taken branches, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; flags=0; redirect_valid=0; redirect_pc=0; flush=0; counters=0.
  - br_ready=1, since it is combinational and equals (state==IDLE).
- Flag register:
  - Loads alu_flags on any clock where alu_flags_we=1, in every state.
  - It is otherwise held.
- Condition encoding:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL always taken; F NV never taken.
- IDLE:
  - Acceptance occurs when br_valid & br_ready.
  - On acceptance, capture br_cond, br_target and a flag snapshot, then go to RESOLVE.
  - Snapshot forwarding: if alu_flags_we=1 in the acceptance cycle, the snapshot is alu_flags; otherwise it is flags.
- RESOLVE (1 cycle):
  - Evaluate the condition on the snapshot.
  - Taken: increment taken_cnt, set redirect_valid=1, redirect_pc=captured target, go to REDIRECT.
  - Not taken: increment nottaken_cnt, go to IDLE.
  - Not-taken branch latency is 2 cycles from acceptance to br_ready=1.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready=1.
  - On handshake, redirect_valid drops the next cycle.
  - If FLUSH_CYCLES>0: go to FLUSH with the down-counter loaded to FLUSH_CYCLES and flush=1.
  - If FLUSH_CYCLES=0: go to IDLE.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES consecutive cycles, then flush=0 and state goes to IDLE.
  - No new branch is accepted during RESOLVE, REDIRECT or FLUSH.
- Counters:
  - Saturate at all-ones and do not wrap.
  - cnt_clr wins over a simultaneous increment, so the result is 0.
- Flags arriving after the snapshot do not affect the in-flight branch.
- Reset asserted mid-operation aborts any redirect/flush immediately; no partial redirect is retried.

Test Plan:
- alu_flags_we=1 with flags=0100, then branch EQ target 0x100, redirect_ready=1 → redirect_valid pulse 1 cycle with redirect_pc=0x100; flush high 2 cycles; taken_cnt=1; br_ready back high after.
- flags Z=0, branch EQ → no redirect, flush stays 0, nottaken_cnt=1, br_ready=1 two cycles after acceptance.
- Forwarding: flags=0000, then in the same cycle alu_flags_we=1 with alu_flags=0100 and branch NE → not taken (snapshot Z=1).
- redirect_ready held low 5 cycles → redirect_valid and redirect_pc stable for 5 cycles, br_ready=0, flush starts only after the handshake.
- Sweep all 16 conditions × 16 flag combinations with redirect_ready=1 → taken decision matches the encoding table; AL is always taken and NV never taken.
- Preload counters to all-ones, issue a taken branch → taken_cnt stays all-ones.
- cnt_clr during a RESOLVE increment → counter=0.
- rst_n low during FLUSH → flush=0 and br_ready=1 immediately.
